// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor (diff = a - b), LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the first WIDTH-1 result bits; the last bit joins them on completion.
  logic [WIDTH-2:0] acc_q, acc_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] full;

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;

  // Next-state, bit-slice datapath and handshake outputs.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    busy     = 1'b0;
    done     = 1'b0;

    d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    full    = {d_bit, acc_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          br_d    = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        acc_d = full[WIDTH-1:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d   = full;
          borrow_d = br_next;
          // Signed overflow only when operand signs differ and the result sign leaves a's sign.
          ovf_d    = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] last_diff = '0;
  logic         last_borrow = 1'b0;
  logic         last_ovf = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y)) & ((1 << W) - 1);
    return W'(r);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // mode 0: quiet inputs, 1: one ignored start pulse mid-op, 2: random input noise
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int mode);
    int done_cyc, busy_cnt, ndone;
    logic [W-1:0] ed;
    logic eb, eo;
    ed = ref_diff(ta, tb);
    eb = ref_borrow(ta, tb);
    eo = ref_ovf(ta, tb);
    done_cyc = -1;
    busy_cnt = 0;
    ndone = 0;
    @(negedge clk);
    a = ta;
    b = tb;
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        ndone++;
        done_cyc = i;
        start = 1'b0;
        check("diff", diff, ed);
        check("borrow_out", borrow_out, eb);
        check("ovf", ovf, eo);
      end else if (done_cyc < 0) begin
        if (i == 2 || i == 6) begin
          check("diff_hold", diff, last_diff);
          check("borrow_hold", borrow_out, last_borrow);
          check("ovf_hold", ovf, last_ovf);
        end
        case (mode)
          1: begin
            start = (i == 3);
            if (i == 3) begin
              a = 8'hFF;
              b = 8'h00;
            end
          end
          2: begin
            start = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
          end
          default: start = 1'b0;
        endcase
      end
      if (done_cyc > 0 && !busy) break;
    end
    check("busy_cycles", busy_cnt, W + 1);
    check("done_latency", done_cyc, W + 1);
    check("done_pulses", ndone, 1);
    @(negedge clk);
    check("idle_done", done, 1'b0);
    last_diff = ed;
    last_borrow = eb;
    last_ovf = eo;
  endtask

  initial begin
    int prev_done, nd;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b0;

    do_op(8'h5A, 8'h23, 0);
    do_op(8'h10, 8'h20, 0);
    do_op(8'h00, 8'h00, 0);
    do_op(8'h80, 8'h01, 0);
    do_op(8'h7F, 8'hFF, 0);
    do_op(8'h05, 8'h03, 1);

    // Reset asserted between edges mid-operation.
    @(negedge clk);
    a = 8'h40;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_borrow", borrow_out, 1'b0);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk);
    check("abort_no_done", done, 1'b0);
    rst = 1'b0;
    last_diff = '0;
    last_borrow = 1'b0;
    last_ovf = 1'b0;
    do_op(8'h09, 8'h04, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    prev_done = -1;
    nd = 0;
    for (int i = 1; i <= 60 && nd < 3; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        check("b2b_diff", diff, 8'h22);
        if (prev_done >= 0) check("b2b_spacing", i - prev_done, W + 2);
        prev_done = i;
        if (nd == 3) start = 1'b0;
      end
    end
    check("b2b_count", nd, 3);
    start = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("b2b_idle", busy, 1'b0);
    last_diff = 8'h22;
    last_borrow = 1'b0;
    last_ovf = 1'b0;

    for (int k = 0; k < 30; k++) begin
      do_op(W'($urandom), W'($urandom), (k % 2 == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
